huffman_sym_encoder: RTL and testbench
======================================

Name: huffman_sym_encoder

Overview:
- Upstream stage of the parallel-to-serial serializer.
- Accepts 4-bit source symbols (0-9) through a valid/ready handshake and buffers them in a small FIFO.
- Looks each symbol up in a programmable code table (code bits plus length) and drives the serializer's data, data_len and trans_start inputs, one framed codeword at a time.

Parameters:
- FIFO_DEPTH, 4, symbol FIFO entries (power of 2, >=2)
- NUM_SYM, 10, number of legal symbols (0..NUM_SYM-1)
- CODE_W, 9, maximum code length in bits
- LEN_W, 4, width of the length field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- sym_valid  in  1  symbol offered
- sym  in  4  symbol value
- sym_ready  out  1  FIFO not full
- tbl_we  in  1  code table write strobe
- tbl_addr  in  4  table entry index
- tbl_code  in  CODE_W  code bits, right-aligned, MSB = first transmitted bit
- tbl_len  in  LEN_W  code length in bits, 1..CODE_W
- data  out  CODE_W  current codeword to the serializer
- data_len  out  LEN_W  current code length in bits
- trans_start  out  1  level; high for exactly data_len cycles per codeword
- sym_err  out  1  one-cycle pulse when a symbol is dropped
- busy  out  1  FIFO non-empty or codeword in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: data=0, data_len=0, trans_start=0, sym_err=0, busy=0. FIFO is empty, so sym_ready=1 one cycle after release. FSM is in IDLE. All table entries are cleared (len=0, code=0).
- Table write:
  - Entry tbl_addr is updated at the edge where tbl_we=1.
  - Writes with tbl_addr >= NUM_SYM are ignored.
  - A lookup in the same cycle as a write to the same entry sees the OLD value.
  - A codeword already latched into data/data_len is never altered by a write.
- Input handshake:
  - A symbol is pushed when sym_valid & sym_ready.
  - sym_ready = ~full, registered-state based; there is no combinational path from sym_valid.
  - FIFO order is strict.
  - Simultaneous push and pop when full is not permitted, because ready is already low.
  - Simultaneous push and pop otherwise keeps the count unchanged.
- FSM states: IDLE, SEND, GAP.
  - IDLE, FIFO non-empty: pop the head and look it up combinationally.
    - If sym >= NUM_SYM, or the entry len is 0 or > CODE_W: drop the symbol, pulse sym_err next cycle, stay in IDLE.
    - Otherwise register data, data_len and bit counter cnt=len, set trans_start=1, go to SEND.
  - SEND: cnt decrements each cycle. When cnt reaches 1, trans_start=0 at the next edge and the FSM goes to GAP. trans_start is therefore high for exactly data_len cycles.
  - GAP: exactly one cycle with trans_start=0, then IDLE. This guarantees a rising and falling edge per codeword for the serializer's start/done detection.
- Latency: symbol accepted at edge k on an empty, idle block -> trans_start high after edge k+1.
- Back-to-back throughput: one codeword per len+2 cycles (SEND + GAP + IDLE pop).
- Stability: data and data_len are held stable for the whole time trans_start is high and through the GAP cycle.
- busy = FIFO non-empty OR state != IDLE.
- Reset mid-operation: trans_start drops immediately (asynchronous). FIFO contents and the table are lost. There is no partial codeword resume.

Decomposition:
- Shared package: CODE_W, LEN_W, NUM_SYM constants; FSM state enum (IDLE/SEND/GAP); code table entry struct {code, len}.
- One natural sub-module: sym_fifo, a synchronous FIFO with full/empty flags and pointer wrap via an extra MSB.
- Code table register file and FSM live in the top module.

Test Plan:
- Program sym 3 = code 0b101 len 3; push 3 -> trans_start high for 3 cycles starting at the cycle after acceptance; data=0x005, data_len=3 stable; busy falls after GAP+IDLE.
- Program sym 0 = 0b1 len 1, sym 9 = 0b111111110 len 9; push 0,9,0 back-to-back -> trans_start pulses of 1, 9, 1 cycles, each separated by exactly 2 low cycles, order preserved.
- Push 5 symbols with sym_valid held while codewords are long -> sym_ready low after 4 queued (FIFO_DEPTH=4); the 5th is accepted only after the first pop; no loss or duplication.
- Push sym 12, and push unprogrammed sym 7 (len 0) -> each dropped, sym_err one-cycle pulse each, trans_start never rises, the next valid symbol is sent normally.
- Rewrite sym 3's table entry while its codeword is in SEND -> in-flight data unchanged; the next sym 3 uses the new code.
- Assert rst_n=0 mid-SEND -> trans_start, data, data_len, busy go 0 immediately; after release sym_ready=1 and the table is cleared (pushing sym 3 gives sym_err).

Source files
------------

// File: rtl/huffman_sym_encoder_pkg.sv
// Shared constants, FSM state encoding and code table entry layout for the
// Huffman symbol encoder.
package huffman_sym_encoder_pkg;

  localparam int unsigned CODE_W  = 9;   // maximum code length in bits
  localparam int unsigned LEN_W   = 4;   // width of the length field
  localparam int unsigned NUM_SYM = 10;  // legal symbols are 0..NUM_SYM-1
  localparam int unsigned SYM_W   = 4;   // symbol / table index width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One code table entry: right-aligned code bits plus length.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } tbl_entry_t;

endpackage

// File: rtl/huffman_sym_encoder_sym_fifo.sv
// Synchronous symbol FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   rdata_c         head entry, valid while !empty_c
//   full_c, empty_c flags decoded from the registered pointers
module huffman_sym_encoder_sym_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/huffman_sym_encoder.sv
// Huffman symbol encoder: buffers source symbols, looks each one up in a
// programmable code table and frames one codeword at a time for the
// downstream serializer (trans_start high for exactly data_len cycles,
// followed by at least two low cycles).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   sym_valid, sym, sym_ready          symbol input handshake
//   tbl_we, tbl_addr, tbl_code, tbl_len code table write port
//   data, data_len, trans_start        framed codeword to the serializer
//   sym_err                            one-cycle pulse per dropped symbol
//   busy                               FIFO non-empty or codeword in flight
module huffman_sym_encoder
  import huffman_sym_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym,
  output logic              sym_ready,
  input  logic              tbl_we,
  input  logic [SYM_W-1:0]  tbl_addr,
  input  logic [CODE_W-1:0] tbl_code,
  input  logic [LEN_W-1:0]  tbl_len,
  output logic [CODE_W-1:0] data,
  output logic [LEN_W-1:0]  data_len,
  output logic              trans_start,
  output logic              sym_err,
  output logic              busy
);

  tbl_entry_t        tbl [NUM_SYM];
  tbl_entry_t        entry_c;
  logic              entry_ok_c;

  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [SYM_W-1:0]  head_c;
  logic              push_c;
  logic              pop_c;

  state_t            state;
  state_t            state_n;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_n;
  logic [CODE_W-1:0] data_n;
  logic [LEN_W-1:0]  data_len_n;
  logic              trans_start_n;
  logic              sym_err_n;

  assign sym_ready = ~fifo_full_c;
  assign push_c    = sym_valid & ~fifo_full_c;
  assign busy      = ~fifo_empty_c | (state != ST_IDLE);

  huffman_sym_encoder_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SYM_W)
  ) u_sym_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wdata   (sym),
    .pop     (pop_c),
    .rdata_c (head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Code table; a lookup in the write cycle reads the pre-write entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SYM; i++) tbl[i] <= '0;
    end else if (tbl_we && (tbl_addr < SYM_W'(NUM_SYM))) begin
      tbl[tbl_addr] <= '{code: tbl_code, len: tbl_len};
    end
  end

  // Head lookup; out-of-range symbols and unusable lengths are rejected
  always_comb begin
    entry_c    = '0;
    entry_ok_c = 1'b0;
    if (head_c < SYM_W'(NUM_SYM)) begin
      entry_c    = tbl[head_c];
      entry_ok_c = (entry_c.len != '0) && (entry_c.len <= LEN_W'(CODE_W));
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      data        <= '0;
      data_len    <= '0;
      trans_start <= 1'b0;
      sym_err     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      data        <= data_n;
      data_len    <= data_len_n;
      trans_start <= trans_start_n;
      sym_err     <= sym_err_n;
    end
  end

  // Next-state and output logic; data/data_len only change on a pop in IDLE
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    data_n        = data;
    data_len_n    = data_len;
    trans_start_n = trans_start;
    sym_err_n     = 1'b0;
    pop_c         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c = 1'b1;
          if (entry_ok_c) begin
            data_n        = entry_c.code;
            data_len_n    = entry_c.len;
            cnt_n         = entry_c.len;
            trans_start_n = 1'b1;
            state_n       = ST_SEND;
          end else begin
            sym_err_n = 1'b1;
          end
        end
      end
      ST_SEND: begin
        cnt_n = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) begin
          trans_start_n = 1'b0;
          state_n       = ST_GAP;
        end
      end
      ST_GAP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n       = ST_IDLE;
        trans_start_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_huffman_sym_encoder.sv
// Directed testbench for huffman_sym_encoder. Outputs are sampled and inputs
// driven on the falling clock edge; a monitor records each trans_start pulse.
module tb_huffman_sym_encoder;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [3:0] sym;
  logic       sym_ready;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [8:0] tbl_code;
  logic [3:0] tbl_len;
  logic [8:0] data;
  logic [3:0] data_len;
  logic       trans_start;
  logic       sym_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [8:0] d;
    logic [3:0] l;
    int         run;
    int         gap;
  } rec_t;

  rec_t       rec_q [$];
  logic       in_run = 1'b0;
  logic [8:0] cur_d = '0;
  logic [3:0] cur_l = '0;
  int         run_cnt = 0;
  int         low_cnt = 999;
  int         gap_b = 0;
  int         stab_viol = 0;

  logic [3:0] t3_sym [6] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd9, 4'd3};
  logic [8:0] t3_d   [6] = '{9'h0AA, 9'h155, 9'h0F0, 9'h00F, 9'h1FE, 9'h005};
  logic [3:0] t3_l   [6] = '{4'd8, 4'd9, 4'd8, 4'd7, 4'd9, 4'd3};
  logic [3:0] bad_sym [3] = '{4'd12, 4'd7, 4'd6};

  huffman_sym_encoder #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .sym_ready   (sym_ready),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_code    (tbl_code),
    .tbl_len     (tbl_len),
    .data        (data),
    .data_len    (data_len),
    .trans_start (trans_start),
    .sym_err     (sym_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: length of each high run, low cycles before it, and
  // whether data/data_len moved while high or in the following low cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_run  = 1'b0;
      low_cnt = 999;
    end else if (trans_start) begin
      if (!in_run) begin
        in_run  = 1'b1;
        cur_d   = data;
        cur_l   = data_len;
        run_cnt = 1;
        gap_b   = low_cnt;
      end else begin
        run_cnt++;
        if (data != cur_d || data_len != cur_l) stab_viol++;
      end
    end else begin
      if (in_run) begin
        rec_q.push_back('{d: cur_d, l: cur_l, run: run_cnt, gap: gap_b});
        in_run  = 1'b0;
        low_cnt = 1;
        if (data != cur_d || data_len != cur_l) stab_viol++;
      end else if (low_cnt < 999) begin
        low_cnt++;
      end
    end
  end

  task automatic tbl_write(input logic [3:0] a, input logic [8:0] c, input logic [3:0] l);
    tbl_we   = 1'b1;
    tbl_addr = a;
    tbl_code = c;
    tbl_len  = l;
    @(negedge clk);
    tbl_we   = 1'b0;
  endtask

  // Offer a symbol; returns at the falling edge after it was accepted
  task automatic push(input logic [3:0] s);
    int n = 0;
    sym       = s;
    sym_valid = 1'b1;
    while (!sym_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_ready_timeout", 32'(sym_ready), 1);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || trans_start) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(busy), 0);
    @(negedge clk);
  endtask

  // Expect a dropped symbol: sym_err pulses exactly once, no codeword
  task automatic expect_drop(input logic [3:0] s);
    push(s);
    check("drop_err_early", 32'(sym_err), 0);
    @(negedge clk);
    check("drop_err_pulse", 32'(sym_err), 1);
    check("drop_ts_low", 32'(trans_start), 0);
    @(negedge clk);
    check("drop_err_clear", 32'(sym_err), 0);
    check("drop_busy", 32'(busy), 0);
    check("drop_ts_low2", 32'(trans_start), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym       = '0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_code  = '0;
    tbl_len   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_data", 32'(data), 0);
    check("rst_len", 32'(data_len), 0);
    check("rst_ts", 32'(trans_start), 0);
    check("rst_err", 32'(sym_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(sym_ready), 1);

    // Single codeword: latency, width and data
    tbl_write(4'd3, 9'h005, 4'd3);
    rec_q.delete();
    push(4'd3);
    check("t1_ts_before", 32'(trans_start), 0);
    check("t1_busy_queued", 32'(busy), 1);
    @(negedge clk);
    check("t1_ts_rise", 32'(trans_start), 1);
    check("t1_data", 32'(data), 32'h005);
    check("t1_len", 32'(data_len), 3);
    @(negedge clk);
    check("t1_ts_c2", 32'(trans_start), 1);
    @(negedge clk);
    check("t1_ts_c3", 32'(trans_start), 1);
    @(negedge clk);
    check("t1_ts_fall", 32'(trans_start), 0);
    check("t1_busy_gap", 32'(busy), 1);
    check("t1_data_gap", 32'(data), 32'h005);
    @(negedge clk);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_pulses", 32'(rec_q.size()), 1);

    // Back-to-back 1/9/1-bit codewords
    tbl_write(4'd0, 9'h001, 4'd1);
    tbl_write(4'd9, 9'h1FE, 4'd9);
    rec_q.delete();
    push(4'd0);
    push(4'd9);
    push(4'd0);
    wait_idle();
    check("t2_pulses", 32'(rec_q.size()), 3);
    if (rec_q.size() == 3) begin
      check("t2_run0", 32'(rec_q[0].run), 1);
      check("t2_d0", 32'(rec_q[0].d), 32'h001);
      check("t2_run1", 32'(rec_q[1].run), 9);
      check("t2_d1", 32'(rec_q[1].d), 32'h1FE);
      check("t2_l1", 32'(rec_q[1].l), 9);
      check("t2_gap1", 32'(rec_q[1].gap), 2);
      check("t2_run2", 32'(rec_q[2].run), 1);
      check("t2_d2", 32'(rec_q[2].d), 32'h001);
      check("t2_gap2", 32'(rec_q[2].gap), 2);
    end

    // FIFO fill: first symbol pops at once, four more fill the queue
    tbl_write(4'd1, 9'h0AA, 4'd8);
    tbl_write(4'd2, 9'h155, 4'd9);
    tbl_write(4'd4, 9'h0F0, 4'd8);
    tbl_write(4'd5, 9'h00F, 4'd7);
    rec_q.delete();
    for (int i = 0; i < 5; i++) push(t3_sym[i]);
    check("t3_ready_full", 32'(sym_ready), 0);
    push(t3_sym[5]);
    wait_idle();
    check("t3_pulses", 32'(rec_q.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rec_q.size()) begin
        check($sformatf("t3_d%0d", i), 32'(rec_q[i].d), 32'(t3_d[i]));
        check($sformatf("t3_l%0d", i), 32'(rec_q[i].l), 32'(t3_l[i]));
        check($sformatf("t3_run%0d", i), 32'(rec_q[i].run), 32'(t3_l[i]));
        if (i > 0) check($sformatf("t3_gap%0d", i), 32'(rec_q[i].gap), 2);
      end
    end

    // Dropped symbols: out of range, unprogrammed, length above CODE_W
    tbl_write(4'd6, 9'h000, 4'd12);
    rec_q.delete();
    for (int i = 0; i < 3; i++) expect_drop(bad_sym[i]);
    check("t4_no_pulse", 32'(rec_q.size()), 0);
    push(4'd3);
    wait_idle();
    check("t4_next_pulses", 32'(rec_q.size()), 1);
    if (rec_q.size() == 1) check("t4_next_d", 32'(rec_q[0].d), 32'h005);

    // Table rewrites: same-edge write sees old entry; mid-SEND write
    // leaves the in-flight codeword alone
    rec_q.delete();
    push(4'd3);
    tbl_write(4'd3, 9'h00C, 4'd5);
    wait_idle();
    push(4'd3);
    @(negedge clk);
    tbl_write(4'd3, 9'h003, 4'd2);
    wait_idle();
    push(4'd3);
    wait_idle();
    check("t5_pulses", 32'(rec_q.size()), 3);
    if (rec_q.size() == 3) begin
      check("t5_d0", 32'(rec_q[0].d), 32'h005);
      check("t5_run0", 32'(rec_q[0].run), 3);
      check("t5_d1", 32'(rec_q[1].d), 32'h00C);
      check("t5_run1", 32'(rec_q[1].run), 5);
      check("t5_d2", 32'(rec_q[2].d), 32'h003);
      check("t5_run2", 32'(rec_q[2].run), 2);
    end
    check("stability", 32'(stab_viol), 0);

    // Reset in the middle of a codeword
    push(4'd9);
    @(negedge clk);
    @(negedge clk);
    check("t6_ts_sending", 32'(trans_start), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ts", 32'(trans_start), 0);
    check("t6_rst_data", 32'(data), 0);
    check("t6_rst_len", 32'(data_len), 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(sym_ready), 1);
    expect_drop(4'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
